// File: rtl/cache_req_queue.sv
// cache_req_queue: buffers CPU load/store requests in a small FIFO and
// serialises them onto a single-outstanding cache port. Each accepted
// request produces exactly one in-order response pulse carrying load data
// or an error flag (misalignment, illegal control, or cache timeout).
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1; req_ready depends only on FIFO occupancy. The cache
// accepts an access when cache_rdy falls while ren/wen is held, and
// completes it when cache_rdy returns high. Responses are never
// back-pressured.
`timescale 1ns/1ps

module cache_req_queue #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_loadcntrl,
  input  logic [2:0]  req_storecntrl,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        ren,
  output logic        wen,
  output logic [31:0] addr,
  output logic [31:0] din,
  output logic [4:0]  loadcntrl,
  output logic [2:0]  storecntrl,
  input  logic        cache_rdy,
  input  logic [31:0] dout,
  output logic [2:0]  dbg_state
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  lc;
    logic [2:0]  sc;
  } req_t;

  state_t state, state_n;

  // Request FIFO storage and pointers
  req_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic           full, empty, push, pop;

  // Working copy of the request being serviced
  req_t             cur;
  logic             seen_rdy;
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic [31:0]      rdata_q;
  logic             err_q;

  // Request legality
  logic lc_onehot, sc_onehot, chk_err;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign req_ready = !full;
  assign push      = req_valid && !full;
  // Pop only from a registered non-empty count, so a freshly pushed entry
  // is never popped in the cycle it arrives.
  assign pop       = (state == IDLE) && !empty;
  assign tmo_hit   = (tmo_cnt == TMO_LAST);
  assign dbg_state = state;

  // FIFO pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO data write; contents are don't-care while the entry is empty
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{we: req_we, addr: req_addr, wdata: req_wdata,
                       lc: req_loadcntrl, sc: req_storecntrl};
    end
  end

  // Legality of the latched request: exactly one control bit for its type
  // and natural alignment for word and halfword accesses.
  always_comb begin
    lc_onehot = (cur.lc != 5'd0) && ((cur.lc & (cur.lc - 5'd1)) == 5'd0);
    sc_onehot = (cur.sc != 3'd0) && ((cur.sc & (cur.sc - 3'd1)) == 3'd0);
    chk_err   = 1'b0;
    if (cur.we) begin
      chk_err = !sc_onehot
             || (cur.sc[2] && (cur.addr[1:0] != 2'b00))
             || (cur.sc[1] && cur.addr[0]);
    end else begin
      chk_err = !lc_onehot
             || (cur.lc[2] && (cur.addr[1:0] != 2'b00))
             || ((cur.lc[1] || cur.lc[4]) && cur.addr[0]);
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // FSM next-state: timeout wins in ISSUE, completion wins in WAIT
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (!empty) state_n = CHECK;
      CHECK: state_n = chk_err ? RESP : ISSUE;
      ISSUE: begin
        if (tmo_hit)                     state_n = RESP;
        else if (seen_rdy && !cache_rdy) state_n = WAIT;
      end
      WAIT:  if (cache_rdy || tmo_hit) state_n = RESP;
      RESP:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Working registers, acceptance tracking, timeout and response capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      cur      <= '0;
      seen_rdy <= 1'b0;
      tmo_cnt  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            cur     <= mem[rd_ptr];
            rdata_q <= '0;
            err_q   <= 1'b0;
          end
        end
        CHECK: begin
          err_q    <= chk_err;
          seen_rdy <= 1'b0;
          tmo_cnt  <= '0;
        end
        ISSUE: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (cache_rdy) seen_rdy <= 1'b1;
          if (tmo_hit)   err_q <= 1'b1;
        end
        WAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (cache_rdy) begin
            if (!cur.we) rdata_q <= dout;
          end else if (tmo_hit) begin
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Cache port: driven only while the access is being offered in ISSUE
  always_comb begin
    ren        = 1'b0;
    wen        = 1'b0;
    addr       = '0;
    din        = '0;
    loadcntrl  = '0;
    storecntrl = '0;
    if (state == ISSUE) begin
      addr = cur.addr;
      if (cur.we) begin
        wen        = 1'b1;
        din        = cur.wdata;
        storecntrl = cur.sc;
      end else begin
        ren       = 1'b1;
        loadcntrl = cur.lc;
      end
    end
  end

  assign rsp_valid = (state == RESP);
  assign rsp_rdata = (state == RESP) ? rdata_q : 32'd0;
  assign rsp_err   = (state == RESP) && err_q;

  a_excl_rw: assert property (@(posedge clk) disable iff (!rst) !(ren && wen));
  a_count_ok: assert property (@(posedge clk) disable iff (!rst) count <= FULL_CNT);

endmodule

// File: tb/tb_cache_req_queue.sv
// Directed bench for cache_req_queue: each task drives one scenario and
// checks the DUT against hand-computed values. Inputs change and outputs
// are sampled on the falling clock edge.
`timescale 1ns/1ps

module tb_cache_req_queue;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd3;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_loadcntrl;
  logic [2:0]  req_storecntrl;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        ren;
  logic        wen;
  logic [31:0] addr;
  logic [31:0] din;
  logic [4:0]  loadcntrl;
  logic [2:0]  storecntrl;
  logic        cache_rdy;
  logic [31:0] dout;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] obs_data_q[$];
  logic        obs_err_q[$];

  cache_req_queue #(.DEPTH(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_loadcntrl(req_loadcntrl), .req_storecntrl(req_storecntrl),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ren(ren), .wen(wen), .addr(addr), .din(din),
    .loadcntrl(loadcntrl), .storecntrl(storecntrl),
    .cache_rdy(cache_rdy), .dout(dout), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver: present one request at a falling edge and hold it until taken
  task automatic push_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [4:0] lc, input logic [2:0] sc);
    int n;
    n = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
    req_loadcntrl = lc; req_storecntrl = sc;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL push_accept got=stuck exp=accepted addr=%h", a);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Cache responder: accepts each access after one ready cycle, returns
  // addr ^ 0x5a5a0000 as read data, and logs every response seen.
  task automatic serve(input int n_rsp, input int budget, output int got);
    int cyc;
    logic armed;
    logic [31:0] lat;
    got = 0; cyc = 0; armed = 1'b0; lat = 32'd0;
    while (got < n_rsp && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) begin
        obs_data_q.push_back(rsp_rdata);
        obs_err_q.push_back(rsp_err);
        got++;
      end
      if (!cache_rdy) begin
        cache_rdy = 1'b1;
        dout = lat ^ 32'h5a5a_0000;
      end else if (ren || wen) begin
        if (armed) begin
          cache_rdy = 1'b0;
          armed = 1'b0;
          lat = addr;
          dout = 32'hdead_0000;
        end else begin
          armed = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    total++; if ({ren, wen, rsp_valid, rsp_err} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {ren, wen, rsp_valid, rsp_err}); end
    total++; if ({addr, din, rsp_rdata} !== 96'd0) begin bad++; $display("FAIL reset_buses got=%h exp=0", {addr, din, rsp_rdata}); end
    total++; if ({loadcntrl, storecntrl} !== 8'd0) begin bad++; $display("FAIL reset_ctrl got=%h exp=0", {loadcntrl, storecntrl}); end
    total++; if (dbg_state !== S_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load();
    int n;
    cache_rdy = 1'b1; dout = 32'h0;
    push_req(1'b0, 32'hace1_2004, 32'h0, 5'b00100, 3'b000);
    n = 0;
    while (!ren && n < 20) begin @(negedge clk); n++; end
    total++; if (ren !== 1'b1 || wen !== 1'b0) begin bad++; $display("FAIL load_ren got=%b%b exp=10", ren, wen); end
    total++; if (addr !== 32'hace1_2004) begin bad++; $display("FAIL load_addr got=%h exp=ace12004", addr); end
    total++; if (loadcntrl !== 5'b00100 || storecntrl !== 3'b000) begin bad++; $display("FAIL load_ctrl got=%b/%b exp=00100/000", loadcntrl, storecntrl); end
    @(negedge clk);
    total++; if (ren !== 1'b1) begin bad++; $display("FAIL load_ren_hold got=%b exp=1", ren); end
    cache_rdy = 1'b0;
    @(negedge clk);
    total++; if (ren !== 1'b0 || loadcntrl !== 5'd0 || dbg_state !== S_WAIT) begin bad++; $display("FAIL load_wait got=ren%b lc%b st%0d exp=ren0 lc0 st3", ren, loadcntrl, dbg_state); end
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL load_early_rsp got=%b exp=0", rsp_valid); end
    cache_rdy = 1'b1; dout = 32'h1234_5678;
    @(negedge clk);
    dout = 32'h0;
    total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_5678 || rsp_err !== 1'b0) begin bad++; $display("FAIL load_rsp got=v%b d%h e%b exp=v1 d12345678 e0", rsp_valid, rsp_rdata, rsp_err); end
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0 || dbg_state !== S_IDLE) begin bad++; $display("FAIL load_rsp_pulse got=v%b st%0d exp=v0 st0", rsp_valid, dbg_state); end
  endtask

  task automatic test_store();
    int n;
    cache_rdy = 1'b1; dout = 32'h55aa_55aa;
    push_req(1'b1, 32'hace1_2000, 32'hdead_beef, 5'b00000, 3'b100);
    n = 0;
    while (!wen && n < 20) begin @(negedge clk); n++; end
    total++; if (wen !== 1'b1 || ren !== 1'b0) begin bad++; $display("FAIL store_wen got=%b%b exp=01", ren, wen); end
    total++; if (din !== 32'hdead_beef || addr !== 32'hace1_2000) begin bad++; $display("FAIL store_bus got=%h@%h exp=deadbeef@ace12000", din, addr); end
    total++; if (storecntrl !== 3'b100 || loadcntrl !== 5'd0) begin bad++; $display("FAIL store_ctrl got=%b/%b exp=100/00000", storecntrl, loadcntrl); end
    @(negedge clk);
    cache_rdy = 1'b0;
    @(negedge clk);
    total++; if (wen !== 1'b0 || storecntrl !== 3'd0) begin bad++; $display("FAIL store_drop got=%b/%b exp=0/000", wen, storecntrl); end
    cache_rdy = 1'b1;
    @(negedge clk);
    total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin bad++; $display("FAIL store_rsp got=v%b d%h e%b exp=v1 d0 e0", rsp_valid, rsp_rdata, rsp_err); end
    @(negedge clk);
  endtask

  task automatic test_errors();
    logic        e_we   [4];
    logic [31:0] e_addr [4];
    logic [4:0]  e_lc   [4];
    logic [2:0]  e_sc   [4];
    int cyc;
    logic acc;
    e_we[0] = 1'b0; e_addr[0] = 32'hace1_2002; e_lc[0] = 5'b00100; e_sc[0] = 3'b000;
    e_we[1] = 1'b1; e_addr[1] = 32'hbeef_2001; e_lc[1] = 5'b00000; e_sc[1] = 3'b010;
    e_we[2] = 1'b0; e_addr[2] = 32'hace1_2000; e_lc[2] = 5'b00110; e_sc[2] = 3'b000;
    e_we[3] = 1'b1; e_addr[3] = 32'hace1_2000; e_lc[3] = 5'b00000; e_sc[3] = 3'b000;
    cache_rdy = 1'b1; dout = 32'hffff_ffff;
    for (int i = 0; i < 4; i++) begin
      push_req(e_we[i], e_addr[i], 32'h0bad_0bad, e_lc[i], e_sc[i]);
      cyc = 0; acc = 1'b0;
      while (!rsp_valid && cyc < 30) begin
        if (ren || wen) acc = 1'b1;
        @(negedge clk);
        cyc++;
      end
      total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'd0) begin bad++; $display("FAIL err_rsp_%0d got=v%b e%b d%h exp=v1 e1 d0", i, rsp_valid, rsp_err, rsp_rdata); end
      total++; if (acc !== 1'b0) begin bad++; $display("FAIL err_no_access_%0d got=%b exp=0", i, acc); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic        b_we   [6];
    logic [31:0] b_addr [6];
    logic [4:0]  b_lc   [6];
    logic [2:0]  b_sc   [6];
    logic [31:0] e, d;
    logic er;
    int got;
    b_we[0] = 1'b0; b_addr[0] = 32'h0000_1000; b_lc[0] = 5'b00100; b_sc[0] = 3'b000;
    b_we[1] = 1'b0; b_addr[1] = 32'h0000_1010; b_lc[1] = 5'b00100; b_sc[1] = 3'b000;
    b_we[2] = 1'b1; b_addr[2] = 32'h0000_1020; b_lc[2] = 5'b00000; b_sc[2] = 3'b100;
    b_we[3] = 1'b0; b_addr[3] = 32'h0000_1032; b_lc[3] = 5'b00010; b_sc[3] = 3'b000;
    b_we[4] = 1'b0; b_addr[4] = 32'h0000_1043; b_lc[4] = 5'b01000; b_sc[4] = 3'b000;
    b_we[5] = 1'b0; b_addr[5] = 32'h0000_1050; b_lc[5] = 5'b00100; b_sc[5] = 3'b000;
    exp_q = {32'h5a5a_1000, 32'h5a5a_1010, 32'h0000_0000,
             32'h5a5a_1032, 32'h5a5a_1043, 32'h5a5a_1050};
    obs_data_q.delete(); obs_err_q.delete();
    cache_rdy = 1'b0; dout = 32'h0;
    for (int i = 0; i < 5; i++) push_req(b_we[i], b_addr[i], 32'h1111_2222, b_lc[i], b_sc[i]);
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL b2b_full got=%b exp=0", req_ready); end
    req_valid = 1'b1; req_we = b_we[5]; req_addr = b_addr[5];
    req_loadcntrl = b_lc[5]; req_storecntrl = b_sc[5];
    @(negedge clk);
    total++; if (req_ready !== 1'b0 || ren !== 1'b1) begin bad++; $display("FAIL b2b_stall got=rdy%b ren%b exp=rdy0 ren1", req_ready, ren); end
    fork
      push_req(b_we[5], b_addr[5], 32'h1111_2222, b_lc[5], b_sc[5]);
      serve(6, 400, got);
    join
    total++; if (got !== 6) begin bad++; $display("FAIL b2b_count got=%0d exp=6", got); end
    for (int i = 0; i < 6; i++) begin
      e = exp_q.pop_front();
      total++;
      if (obs_data_q.size() == 0) begin
        bad++; $display("FAIL b2b_rsp_%0d got=none exp=%h", i, e);
      end else begin
        d = obs_data_q.pop_front();
        er = obs_err_q.pop_front();
        if (d !== e || er !== 1'b0) begin bad++; $display("FAIL b2b_rsp_%0d got=%h e%b exp=%h e0", i, d, er, e); end
      end
    end
  endtask

  task automatic test_timeout();
    int n, cyc, got;
    logic [31:0] d;
    logic er;
    obs_data_q.delete(); obs_err_q.delete();
    cache_rdy = 1'b1; dout = 32'hffff_ffff;
    push_req(1'b0, 32'h0000_2000, 32'h0, 5'b00100, 3'b000);
    push_req(1'b0, 32'h0000_2004, 32'h0, 5'b00100, 3'b000);
    n = 0;
    while (!ren && n < 20) begin @(negedge clk); n++; end
    cyc = 0;
    @(negedge clk); cyc = 1;
    cache_rdy = 1'b0;
    @(negedge clk); cyc = 2;
    total++; if (ren !== 1'b0 || dbg_state !== S_WAIT) begin bad++; $display("FAIL tmo_accept got=ren%b st%0d exp=ren0 st3", ren, dbg_state); end
    while (!rsp_valid && cyc < 200) begin @(negedge clk); cyc++; end
    total++; if (cyc !== 64) begin bad++; $display("FAIL tmo_cycles got=%0d exp=64", cyc); end
    total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'd0 || ren !== 1'b0) begin bad++; $display("FAIL tmo_rsp got=v%b e%b d%h ren%b exp=v1 e1 d0 ren0", rsp_valid, rsp_err, rsp_rdata, ren); end
    @(negedge clk);
    total++; if (dbg_state !== S_IDLE) begin bad++; $display("FAIL tmo_idle got=%0d exp=0", dbg_state); end
    cache_rdy = 1'b1;
    serve(1, 100, got);
    total++;
    if (got !== 1) begin
      bad++; $display("FAIL tmo_next got=%0d rsp exp=1", got);
    end else begin
      d = obs_data_q.pop_front();
      er = obs_err_q.pop_front();
      if (d !== 32'h5a5a_2004 || er !== 1'b0) begin bad++; $display("FAIL tmo_next got=%h e%b exp=5a5a2004 e0", d, er); end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n, rsp_seen, acc_seen;
    cache_rdy = 1'b1; dout = 32'h7777_7777;
    push_req(1'b0, 32'h0000_3000, 32'h0, 5'b00100, 3'b000);
    push_req(1'b0, 32'h0000_3004, 32'h0, 5'b00100, 3'b000);
    n = 0;
    while (!ren && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    cache_rdy = 1'b0;
    @(negedge clk);
    total++; if (dbg_state !== S_WAIT) begin bad++; $display("FAIL rstmid_wait got=%0d exp=3", dbg_state); end
    rst = 1'b0;
    @(negedge clk);
    total++; if ({ren, wen, rsp_valid, rsp_err, req_ready} !== 5'b00001) begin bad++; $display("FAIL rstmid_flags got=%b exp=00001", {ren, wen, rsp_valid, rsp_err, req_ready}); end
    total++; if ({addr, din, rsp_rdata, loadcntrl, storecntrl} !== 104'd0 || dbg_state !== S_IDLE) begin bad++; $display("FAIL rstmid_outs got=%h st%0d exp=0 st0", {addr, din, rsp_rdata}, dbg_state); end
    rst = 1'b1; cache_rdy = 1'b1;
    rsp_seen = 0; acc_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid) rsp_seen++;
      if (ren || wen) acc_seen++;
    end
    total++; if (rsp_seen !== 0 || acc_seen !== 0) begin bad++; $display("FAIL rstmid_abandon got=rsp%0d acc%0d exp=rsp0 acc0", rsp_seen, acc_seen); end
  endtask

  // Test sequence
  initial begin
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    req_loadcntrl = 5'h0; req_storecntrl = 3'h0; cache_rdy = 1'b1; dout = 32'h0;
    test_reset();
    test_load();
    test_store();
    test_errors();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
